// File: rtl/stage2_pkg.sv
// Shared definitions for the stage2 pattern checker: stimulus field layout,
// golden packing order and the run-control state encoding.
package stage2_pkg;

    localparam int STAGE2_PAT_W  = 20;
    localparam int STAGE2_GOLD_W = 3;
    localparam int STAGE2_CNT_W  = 20;

    // Stimulus word layout, MSB first: {pass1, bonus1, effort, hard, random2}
    localparam int PASS1_MSB   = 19;
    localparam int BONUS1_MSB  = 18;
    localparam int BONUS1_LSB  = 17;
    localparam int EFFORT_MSB  = 16;
    localparam int EFFORT_LSB  = 10;
    localparam int HARD_MSB    = 9;
    localparam int HARD_LSB    = 5;
    localparam int RANDOM2_MSB = 4;
    localparam int RANDOM2_LSB = 0;

    // Golden/actual response layout: {bonus2, pass2}
    localparam int GOLD_BONUS2_MSB = 2;
    localparam int GOLD_BONUS2_LSB = 1;
    localparam int GOLD_PASS2_BIT  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [STAGE2_GOLD_W-1:0] pack_gold(input logic [1:0] bonus2,
                                                           input logic       pass2);
        logic [STAGE2_GOLD_W-1:0] g;
        g = {STAGE2_GOLD_W{1'b0}};
        g[GOLD_BONUS2_MSB:GOLD_BONUS2_LSB] = bonus2;
        g[GOLD_PASS2_BIT] = pass2;
        return g;
    endfunction

endpackage

// File: rtl/stage2_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module stage2_sat_counter
    import stage2_pkg::*;
#(
    parameter int CNT_W = STAGE2_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_r;
    logic             at_max_s;

    assign at_max_s = (count_r == {CNT_W{1'b1}});

    // Count register: clear wins over increment, increment stops at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc && !at_max_s) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/stage2_pattern_checker.sv
// Drives packed stimulus words into the combinational stage2 block and checks its
// {bonus2, pass2} response. Optional first-failure capture: STAGE2_CHK_FIRST_FAIL_EN.
module stage2_pattern_checker
    import stage2_pkg::*;
#(
    parameter int PAT_W  = STAGE2_PAT_W,
    parameter int GOLD_W = STAGE2_GOLD_W,
    parameter int CNT_W  = STAGE2_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pat_valid,
    output logic              pat_ready,
    input  logic [PAT_W-1:0]  pat_data,
    input  logic [GOLD_W-1:0] pat_gold,
    input  logic              pat_last,
    output logic              pass1,
    output logic [1:0]        bonus1,
    output logic [6:0]        effort,
    output logic [4:0]        hard,
    output logic [4:0]        random2,
    input  logic              pass2,
    input  logic [1:0]        bonus2,
    output logic              busy,
    output logic              done,
    output logic              mismatch,
    output logic [CNT_W-1:0]  pat_cnt,
    output logic [CNT_W-1:0]  fail_cnt
`ifdef STAGE2_CHK_FIRST_FAIL_EN
    ,
    output logic [CNT_W-1:0]          first_fail_idx,
    output logic [PAT_W+GOLD_W*2-1:0] first_fail_vec
`endif
);

    state_e state_r;
    state_e state_next_s;

    logic xfer_s;
    logic clear_s;
    logic ready_s, busy_s, done_s;
    logic ready_r, busy_r, done_r, mismatch_r;

    logic        pass1_r;
    logic [1:0]  bonus1_r;
    logic [6:0]  effort_r;
    logic [4:0]  hard_r;
    logic [4:0]  random2_r;
    logic [GOLD_W-1:0] drv_gold_r;
    logic              drv_valid_r;

    logic [GOLD_W-1:0] smp_gold_r;
    logic [GOLD_W-1:0] smp_act_r;
    logic              smp_valid_r;
    logic              miss_s;

    assign xfer_s  = pat_valid && ready_r;
    assign clear_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign miss_s  = smp_valid_r && (smp_act_r != smp_gold_r);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; DRAIN ends once the drive stage is empty, i.e. on the final compare edge
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_next_s = ST_RUN;
                else       state_next_s = ST_IDLE;
            end
            ST_RUN: begin
                if (xfer_s && pat_last) state_next_s = ST_DRAIN;
                else                    state_next_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (!drv_valid_r) state_next_s = ST_DONE;
                else              state_next_s = ST_DRAIN;
            end
            ST_DONE: begin
                if (start) state_next_s = ST_RUN;
                else       state_next_s = ST_DONE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the status flags can be registered with the state
    always_comb begin
        ready_s = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        case (state_next_s)
            ST_RUN: begin
                ready_s = 1'b1;
                busy_s  = 1'b1;
            end
            ST_DRAIN: busy_s = 1'b1;
            ST_DONE:  done_s = 1'b1;
            default: begin
                ready_s = 1'b0;
                busy_s  = 1'b0;
                done_s  = 1'b0;
            end
        endcase
    end

    // Registered status flags and the one-cycle mismatch pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            mismatch_r <= 1'b0;
        end else begin
            ready_r    <= ready_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            mismatch_r <= miss_s;
        end
    end

    // Drive stage: unpack an accepted word onto stage2 and hold it until the next transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass1_r     <= 1'b0;
            bonus1_r    <= 2'b00;
            effort_r    <= 7'd0;
            hard_r      <= 5'd0;
            random2_r   <= 5'd0;
            drv_gold_r  <= {GOLD_W{1'b0}};
            drv_valid_r <= 1'b0;
        end else begin
            drv_valid_r <= xfer_s;
            if (xfer_s) begin
                pass1_r    <= pat_data[PASS1_MSB];
                bonus1_r   <= pat_data[BONUS1_MSB:BONUS1_LSB];
                effort_r   <= pat_data[EFFORT_MSB:EFFORT_LSB];
                hard_r     <= pat_data[HARD_MSB:HARD_LSB];
                random2_r  <= pat_data[RANDOM2_MSB:RANDOM2_LSB];
                drv_gold_r <= pat_gold;
            end else begin
                pass1_r    <= pass1_r;
                bonus1_r   <= bonus1_r;
                effort_r   <= effort_r;
                hard_r     <= hard_r;
                random2_r  <= random2_r;
                drv_gold_r <= drv_gold_r;
            end
        end
    end

    // Sample stage: capture stage2's response one cycle after drive, compared on the following edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_valid_r <= 1'b0;
            smp_gold_r  <= {GOLD_W{1'b0}};
            smp_act_r   <= {GOLD_W{1'b0}};
        end else begin
            smp_valid_r <= drv_valid_r;
            smp_gold_r  <= drv_gold_r;
            smp_act_r   <= pack_gold(bonus2, pass2);
        end
    end

    stage2_sat_counter #(.CNT_W(CNT_W)) u_pat_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear_s),
        .inc   (smp_valid_r),
        .count (pat_cnt)
    );

    stage2_sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear_s),
        .inc   (miss_s),
        .count (fail_cnt)
    );

`ifdef STAGE2_CHK_FIRST_FAIL_EN
    logic [PAT_W-1:0]          smp_stim_r;
    logic                      ff_seen_r;
    logic [CNT_W-1:0]          ff_idx_r;
    logic [PAT_W+GOLD_W*2-1:0] ff_vec_r;

    // Stimulus travels alongside the sampled response so a failure can be reported whole
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_stim_r <= {PAT_W{1'b0}};
        end else begin
            smp_stim_r <= {pass1_r, bonus1_r, effort_r, hard_r, random2_r};
        end
    end

    // First-failure capture; index is the pattern count before this compare increments it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_seen_r <= 1'b0;
            ff_idx_r  <= {CNT_W{1'b0}};
            ff_vec_r  <= {(PAT_W+GOLD_W*2){1'b0}};
        end else if (clear_s) begin
            ff_seen_r <= 1'b0;
            ff_idx_r  <= {CNT_W{1'b0}};
            ff_vec_r  <= {(PAT_W+GOLD_W*2){1'b0}};
        end else if (miss_s && !ff_seen_r) begin
            ff_seen_r <= 1'b1;
            ff_idx_r  <= pat_cnt;
            ff_vec_r  <= {smp_stim_r, smp_gold_r, smp_act_r};
        end else begin
            ff_seen_r <= ff_seen_r;
            ff_idx_r  <= ff_idx_r;
            ff_vec_r  <= ff_vec_r;
        end
    end

    assign first_fail_idx = ff_idx_r;
    assign first_fail_vec = ff_vec_r;
`endif

    assign pat_ready = ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign mismatch  = mismatch_r;
    assign pass1     = pass1_r;
    assign bonus1    = bonus1_r;
    assign effort    = effort_r;
    assign hard      = hard_r;
    assign random2   = random2_r;

endmodule
